regfile_wb_arbiter: RTL and testbench

//   Write-back arbiter and scoreboard: the writer side of the register file's single write port.
//   - Merges ALU results (1-cycle path) and load results (buffered in a small FIFO) into one

---
 rtl/regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Writer side of the register file's single write port. ALU results (1-cycle
//   path) and load results (buffered in a small FIFO) are merged into one
//   registered write per cycle. A per-register pending-write mask lets decode
//   stall on RAW hazards.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   issue_valid, issue_rd    decode issued an instruction that will write issue_rd
//   alu_valid/alu_ready      ALU result handshake, alu_rd/alu_data payload
//   ld_valid/ld_ready        load result handshake into the FIFO, ld_rd/ld_data payload
//   rd_en, rd_addr, rd_data  registered register-file write port
//   busy_mask                bit i set = write to x[i] pending (bit 0 always 0)
//   lq_count                 load FIFO occupancy
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int XLEN     = 32,
   parameter int LQ_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_valid,
   input  logic [4:0]                 issue_rd,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [4:0]                 alu_rd,
   input  logic [XLEN-1:0]            alu_data,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [4:0]                 ld_rd,
   input  logic [XLEN-1:0]            ld_data,
   output logic                       rd_en,
   output logic [4:0]                 rd_addr,
   output logic [XLEN-1:0]            rd_data,
   output logic [31:0]                busy_mask,
   output logic [$clog2(LQ_DEPTH):0]  lq_count
);

   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);
   localparam logic [CW-1:0] HALF_C  = CW'(LQ_DEPTH / 2);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic {
      ALU_PRI = 1'b0,
      DRAIN   = 1'b1
   } arb_state_t;

   arb_state_t          state_r;
   arb_state_t          state_next_s;

   logic [4:0]          lq_rd_mem_r   [LQ_DEPTH];
   logic [XLEN-1:0]     lq_data_mem_r [LQ_DEPTH];
   logic [PW-1:0]       wr_ptr_r;
   logic [PW-1:0]       rd_ptr_r;
   logic [CW-1:0]       count_next_s;

   logic                push_s;
   logic                pop_s;
   logic                fifo_empty_s;
   logic                wr_valid_s;
   logic [4:0]          wr_rd_s;
   logic [XLEN-1:0]     wr_data_s;
   logic [31:0]         busy_next_s;

   assign fifo_empty_s = (lq_count == {CW{1'b0}});
   // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
   assign ld_ready     = (lq_count != DEPTH_C);
   assign push_s       = ld_valid & ld_ready;
   assign count_next_s = lq_count + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};

   // Write-source selection, FIFO pop and ALU ready for the current arbitration state.
   always_comb begin
      alu_ready  = 1'b0;
      pop_s      = 1'b0;
      wr_valid_s = 1'b0;
      wr_rd_s    = alu_rd;
      wr_data_s  = alu_data;
      case (state_r)
         ALU_PRI: begin
            alu_ready = 1'b1;
            if (alu_valid) begin
               wr_valid_s = 1'b1;
            end else if (!fifo_empty_s) begin
               pop_s      = 1'b1;
               wr_valid_s = 1'b1;
               wr_rd_s    = lq_rd_mem_r[rd_ptr_r];
               wr_data_s  = lq_data_mem_r[rd_ptr_r];
            end else begin
               wr_valid_s = 1'b0;
            end
         end
         DRAIN: begin
            if (!fifo_empty_s) begin
               pop_s      = 1'b1;
               wr_valid_s = 1'b1;
               wr_rd_s    = lq_rd_mem_r[rd_ptr_r];
               wr_data_s  = lq_data_mem_r[rd_ptr_r];
            end else begin
               wr_valid_s = 1'b0;
            end
         end
         default: begin
            alu_ready = 1'b0;
         end
      endcase
   end

   // Next arbitration state, decided on the occupancy the FIFO will have after this edge.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ALU_PRI: begin
            if (count_next_s == DEPTH_C) begin
               state_next_s = DRAIN;
            end else begin
               state_next_s = ALU_PRI;
            end
         end
         DRAIN: begin
            if (count_next_s <= HALF_C) begin
               state_next_s = ALU_PRI;
            end else begin
               state_next_s = DRAIN;
            end
         end
         default: begin
            state_next_s = ALU_PRI;
         end
      endcase
   end

   // Pending mask: clear the register written last cycle, then set the newly issued one (set wins).
   always_comb begin
      busy_next_s = busy_mask;
      if (rd_en) begin
         busy_next_s[rd_addr] = 1'b0;
      end else begin
         busy_next_s = busy_mask;
      end
      if (issue_valid) begin
         busy_next_s[issue_rd] = 1'b1;
      end else begin
         busy_next_s = busy_next_s;
      end
      busy_next_s[0] = 1'b0;
   end

   // Arbitration state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ALU_PRI;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         lq_count <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         lq_count <= count_next_s;
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         lq_rd_mem_r[wr_ptr_r]   <= ld_rd;
         lq_data_mem_r[wr_ptr_r] <= ld_data;
      end
   end

   // Registered write port; x0 results are consumed but never written, address/data hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en   <= 1'b0;
         rd_addr <= 5'd0;
         rd_data <= {XLEN{1'b0}};
      end else begin
         rd_en <= wr_valid_s & (wr_rd_s != 5'd0);
         if (wr_valid_s && (wr_rd_s != 5'd0)) begin
            rd_addr <= wr_rd_s;
            rd_data <= wr_data_s;
         end
      end
   end

   // Registered pending-write mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_mask <= 32'd0;
      end else begin
         busy_mask <= busy_next_s;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = 5'd0;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_rd = 5'd0;
   logic [31:0] alu_data = 32'd0;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [4:0]  ld_rd = 5'd0;
   logic [31:0] ld_data = 32'd0;
   logic        rd_en;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [31:0] busy_mask;
   logic [2:0]  lq_count;

   regfile_wb_arbiter #(.XLEN(32), .LQ_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy_mask(busy_mask), .lq_count(lq_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] busy;
      int          count;
      logic        ardy;
   } exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ld_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // reference model state
   ld_t         mq[$];
   bit          m_drain;
   logic [31:0] m_busy;
   bit          m_prev_en;
   logic [4:0]  m_prev_addr;
   logic [4:0]  m_last_addr;
   logic [31:0] m_last_data;

   // pending producer transactions
   bit          a_v, l_v, i_v;
   logic [4:0]  a_rd, l_rd, i_rd;
   logic [31:0] a_data, l_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      m_drain = 1'b0;
      m_busy = 32'd0;
      m_prev_en = 1'b0;
      m_prev_addr = 5'd0;
      m_last_addr = 5'd0;
      m_last_data = 32'd0;
      a_v = 1'b0; l_v = 1'b0; i_v = 1'b0;
   endtask

   // One clock: drive pending transactions, predict the post-edge state, queue it.
   task automatic cycle();
      bit          alu_acc, ld_acc, pop, wr, en;
      logic [4:0]  w_rd;
      logic [31:0] w_data, nb;
      ld_t         item;
      @(negedge clk);
      #1;
      alu_valid = a_v; alu_rd = a_rd; alu_data = a_data;
      ld_valid = l_v; ld_rd = l_rd; ld_data = l_data;
      issue_valid = i_v; issue_rd = i_rd;

      alu_acc = a_v && !m_drain;
      ld_acc  = l_v && (mq.size() < DEPTH);
      pop     = (mq.size() > 0) && (m_drain || !a_v);
      wr = 1'b0; w_rd = 5'd0; w_data = 32'd0;
      if (alu_acc) begin
         wr = 1'b1; w_rd = a_rd; w_data = a_data;
      end else if (pop) begin
         wr = 1'b1; w_rd = mq[0].rd; w_data = mq[0].data;
      end
      if (pop) void'(mq.pop_front());
      if (ld_acc) begin
         item.rd = l_rd; item.data = l_data;
         mq.push_back(item);
      end
      nb = m_busy;
      if (m_prev_en) nb[m_prev_addr] = 1'b0;
      if (i_v) nb[i_rd] = 1'b1;
      nb[0] = 1'b0;
      m_busy = nb;
      en = wr && (w_rd != 5'd0);
      if (en) begin
         m_last_addr = w_rd; m_last_data = w_data;
      end
      m_prev_en = en; m_prev_addr = w_rd;
      if (!m_drain) m_drain = (mq.size() == DEPTH);
      else          m_drain = !(mq.size() <= DEPTH / 2);
      exp_q.push_back('{en, m_last_addr, m_last_data, m_busy, mq.size(), !m_drain});

      if (alu_acc) a_v = 1'b0;
      if (ld_acc) l_v = 1'b0;
      i_v = 1'b0;
   endtask

   task automatic new_alu(input logic [4:0] rd, input logic [31:0] d);
      a_v = 1'b1; a_rd = rd; a_data = d;
   endtask

   task automatic new_ld(input logic [4:0] rd, input logic [31:0] d);
      l_v = 1'b1; l_rd = rd; l_data = d;
   endtask

   // Monitor: compare every DUT post-edge state against the oldest prediction.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rd_en", 32'(rd_en), 32'(e.en));
         chk("rd_addr", 32'(rd_addr), 32'(e.addr));
         chk("rd_data", rd_data, e.data);
         chk("busy_mask", busy_mask, e.busy);
         chk("lq_count", 32'(lq_count), e.count);
         chk("alu_ready", 32'(alu_ready), 32'(e.ardy));
         chk("ld_ready", 32'(ld_ready), 32'(e.count != DEPTH));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #2;
      chk("reset_rd_en", 32'(rd_en), 32'd0);
      chk("reset_busy", busy_mask, 32'd0);
      chk("reset_count", 32'(lq_count), 32'd0);
      chk("reset_rd_data", rd_data, 32'd0);
      chk("reset_alu_ready", 32'(alu_ready), 32'd1);
      @(negedge clk); #1; rst = 1'b0;

      // ALU only
      new_alu(5'd5, 32'hDEADBEEF); cycle(); cycle();

      // collision: ALU x3 first, load x4 on the following cycle
      new_alu(5'd3, 32'h11); new_ld(5'd4, 32'h22); cycle();
      cycle(); cycle(); cycle();

      // FIFO full with continuous ALU traffic -> DRAIN until count falls to half
      for (int i = 0; i < 14; i++) begin
         if (!a_v) new_alu(5'(1 + i), 32'hA000_0000 + 32'(i));
         if (!l_v) new_ld(5'(10 + i), 32'hB000_0000 + 32'(i));
         cycle();
      end
      for (int i = 0; i < 8; i++) cycle();

      // scoreboard: issue x7, write x7, re-issue on the clear cycle
      i_v = 1'b1; i_rd = 5'd7; cycle();
      new_alu(5'd7, 32'h7777); cycle();
      i_v = 1'b1; i_rd = 5'd7; cycle();
      cycle(); cycle();
      new_alu(5'd7, 32'h7778); cycle(); cycle(); cycle();

      // x0 result: consumed, no write, addr/data hold
      i_v = 1'b1; i_rd = 5'd0; new_alu(5'd0, 32'h0BAD); cycle(); cycle(); cycle();

      // reset mid-stream with three loads queued
      for (int i = 0; i < 3; i++) begin
         new_alu(5'(20 + i), 32'hC000_0000 + 32'(i));
         new_ld(5'(24 + i), 32'hD000_0000 + 32'(i));
         i_v = 1'b1; i_rd = 5'(24 + i);
         cycle();
      end
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_rd_en", 32'(rd_en), 32'd0);
      chk("midrst_busy", busy_mask, 32'd0);
      chk("midrst_count", 32'(lq_count), 32'd0);
      model_reset();
      alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
      @(negedge clk); #1; rst = 1'b0;

      // randomized traffic with varying load pressure
      for (int i = 0; i < 600; i++) begin
         int lp;
         lp = (i < 300) ? 40 : 85;
         if (!a_v && $urandom_range(0, 99) < 50) new_alu(5'($urandom_range(0, 31)), $urandom);
         if (!l_v && $urandom_range(0, 99) < lp) new_ld(5'($urandom_range(0, 31)), $urandom);
         if ($urandom_range(0, 99) < 30) begin
            i_v = 1'b1; i_rd = 5'($urandom_range(0, 31));
         end
         cycle();
      end
      for (int i = 0; i < 10; i++) cycle();
      @(negedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
